// File: rtl/word_buffer_arbiter.sv
// rtl/word_buffer_arbiter.sv - round-robin arbiter of per-port one-word slots onto one registered output
module word_buffer_arbiter #(
  parameter int NUM_PORTS  = 4,
  parameter int DATA_WIDTH = 8,
  localparam int PW        = $clog2(NUM_PORTS)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            clear,
  input  logic [NUM_PORTS-1:0]            in_strobe,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] in_data,
  input  logic                            out_ready,
  output logic                            out_valid,
  output logic [DATA_WIDTH-1:0]           out_data,
  output logic [PW-1:0]                   out_port,
  output logic [NUM_PORTS-1:0]            overflow,
  output logic [NUM_PORTS-1:0]            full
);

  logic [DATA_WIDTH-1:0] slot_q [NUM_PORTS];
  logic [DATA_WIDTH-1:0] slot_d [NUM_PORTS];
  logic [NUM_PORTS-1:0]  full_q, full_d;
  logic [NUM_PORTS-1:0]  overflow_q, overflow_d;
  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic [PW-1:0]         out_port_q, out_port_d;
  logic [PW-1:0]         last_grant_q, last_grant_d;

  logic                  free;
  logic                  grant_any;
  logic [PW-1:0]         grant_idx;
  logic                  do_grant;
  int unsigned           cand;

  // Round-robin pick: first full slot after the last granted port, wrapping.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    cand      = 0;
    for (int k = 1; k <= NUM_PORTS; k++) begin
      cand = (int'(last_grant_q) + k) % NUM_PORTS;
      if (!grant_any && full_q[cand]) begin
        grant_any = 1'b1;
        grant_idx = PW'(cand);
      end
    end
  end

  // Next state for the output register, slots, occupancy and overwrite pulses.
  always_comb begin
    free         = !out_valid_q || out_ready;
    do_grant     = free && grant_any;
    slot_d       = slot_q;
    full_d       = full_q;
    overflow_d   = '0;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_port_d   = out_port_q;
    last_grant_d = last_grant_q;

    if (free) begin
      out_valid_d = grant_any;
      if (grant_any) begin
        out_data_d          = slot_q[grant_idx];
        out_port_d          = grant_idx;
        last_grant_d        = grant_idx;
        full_d[grant_idx]   = 1'b0;
      end
    end

    // A strobe always lands in its slot; an unread word lost to it is flagged,
    // unless that same word is leaving through the grant on this edge.
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (in_strobe[i]) begin
        slot_d[i] = in_data[i*DATA_WIDTH +: DATA_WIDTH];
        if (full_q[i] && !(do_grant && grant_idx == PW'(i))) begin
          overflow_d[i] = 1'b1;
        end
        full_d[i] = 1'b1;
      end
    end

    // Flush drops pending words and same-cycle strobes but keeps fairness state.
    if (clear) begin
      slot_d       = slot_q;
      full_d       = '0;
      overflow_d   = '0;
      out_valid_d  = 1'b0;
      out_data_d   = out_data_q;
      out_port_d   = out_port_q;
      last_grant_d = last_grant_q;
    end
  end

  // State registers; reset leaves port 0 with first priority.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_PORTS; i++) slot_q[i] <= '0;
      full_q       <= '0;
      overflow_q   <= '0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_port_q   <= '0;
      last_grant_q <= PW'(NUM_PORTS - 1);
    end else begin
      slot_q       <= slot_d;
      full_q       <= full_d;
      overflow_q   <= overflow_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_port_q   <= out_port_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_port  = out_port_q;
  assign overflow  = overflow_q;
  assign full      = full_q;

endmodule

// File: tb/tb_word_buffer_arbiter.sv
// tb/tb_word_buffer_arbiter.sv - scoreboard bench for word_buffer_arbiter
module tb_word_buffer_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        clear;
  logic [3:0]  in_strobe;
  logic [31:0] in_data;
  logic        out_ready;
  logic        out_valid;
  logic [7:0]  out_data;
  logic [1:0]  out_port;
  logic [3:0]  overflow;
  logic [3:0]  full;

  typedef struct packed {
    logic [1:0] port;
    logic [7:0] data;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  word_buffer_arbiter #(.NUM_PORTS(4), .DATA_WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .clear     (clear),
    .in_strobe (in_strobe),
    .in_data   (in_data),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_port  (out_port),
    .overflow  (overflow),
    .full      (full)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [1:0] p, input logic [7:0] d);
    exp_t e;
    e.port = p;
    e.data = d;
    sb_q.push_back(e);
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    #2;
    rst = 1'b0;
  endtask

  // Every accepted word is compared against the next expected one.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        check("sb_underflow", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("sb_port", {30'd0, out_port}, {30'd0, e.port});
        check("sb_data", {24'd0, out_data}, {24'd0, e.data});
      end
    end
  end

  initial begin
    rst = 1'b1; clear = 1'b0; in_strobe = '0; in_data = '0; out_ready = 1'b0;
    step(2);
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_full", {28'd0, full}, 32'd0);
    check("rst_ovf", {28'd0, overflow}, 32'd0);
    check("rst_data", {24'd0, out_data}, 32'd0);
    check("rst_port", {30'd0, out_port}, 32'd0);
    rst = 1'b0;

    // single strobe, two-cycle latency
    in_strobe = 4'b0100; in_data = 32'h00A5_0000; out_ready = 1'b1;
    push(2'd2, 8'hA5);
    step(1);
    in_strobe = '0;
    check("t1_full", {28'd0, full}, 32'h4);
    check("t1_valid0", {31'd0, out_valid}, 32'd0);
    step(1);
    check("t1_valid1", {31'd0, out_valid}, 32'd1);
    check("t1_port", {30'd0, out_port}, 32'd2);
    check("t1_full2", {28'd0, full}, 32'd0);
    step(1);
    check("t1_valid2", {31'd0, out_valid}, 32'd0);

    // backpressure and fairness from a fresh reset
    out_ready = 1'b0;
    pulse_reset();
    in_strobe = 4'b1111; in_data = 32'h1312_1110;
    push(2'd0, 8'h10); push(2'd1, 8'h11); push(2'd2, 8'h12); push(2'd3, 8'h13);
    step(1);
    in_strobe = '0;
    step(1);
    step(5);
    check("t2_hold_data", {24'd0, out_data}, 32'h10);
    check("t2_hold_port", {30'd0, out_port}, 32'd0);
    check("t2_full", {28'd0, full}, 32'hE);
    out_ready = 1'b1;
    for (int p = 1; p < 4; p++) begin
      step(1);
      check("t2_order", {30'd0, out_port}, p);
    end
    step(1);
    check("t2_drained", {31'd0, out_valid}, 32'd0);
    out_ready = 1'b0;

    // overwrite while slot 1 waits behind port 0
    in_strobe = 4'b0011; in_data = 32'h0000_2105;
    step(1);
    in_strobe = 4'b0010; in_data = 32'h0000_2200;
    step(1);
    in_strobe = '0;
    push(2'd0, 8'h05); push(2'd1, 8'h22);
    check("t3_ovf", {28'd0, overflow}, 32'h2);
    check("t3_out", {24'd0, out_data}, 32'h05);
    check("t3_full", {28'd0, full}, 32'h2);
    step(1);
    check("t3_ovf_once", {28'd0, overflow}, 32'd0);
    out_ready = 1'b1;
    step(2);
    check("t3_drained", {31'd0, out_valid}, 32'd0);
    out_ready = 1'b0;

    // grant and rewrite of slot 3 on the same edge
    in_strobe = 4'b1000; in_data = 32'h3000_0000;
    step(1);
    in_strobe = 4'b1000; in_data = 32'h3100_0000;
    push(2'd3, 8'h30); push(2'd3, 8'h31);
    step(1);
    in_strobe = '0;
    check("t4_data", {24'd0, out_data}, 32'h30);
    check("t4_full", {28'd0, full}, 32'h8);
    check("t4_ovf", {28'd0, overflow}, 32'd0);
    out_ready = 1'b1;
    step(1);
    check("t4_next", {24'd0, out_data}, 32'h31);
    step(1);
    check("t4_drained", {31'd0, out_valid}, 32'd0);
    out_ready = 1'b0;

    // wrap-around after last grant of port 3
    in_strobe = 4'b1001; in_data = 32'h4300_0040;
    push(2'd0, 8'h40); push(2'd3, 8'h43);
    step(1);
    in_strobe = '0;
    step(1);
    check("t5_first", {30'd0, out_port}, 32'd0);
    check("t5_full", {28'd0, full}, 32'h8);
    out_ready = 1'b1;
    step(1);
    check("t5_second", {30'd0, out_port}, 32'd3);
    step(1);
    check("t5_drained", {31'd0, out_valid}, 32'd0);
    out_ready = 1'b0;

    // async reset mid-cycle with a held word and pending slots
    in_strobe = 4'b0111; in_data = 32'h0052_5150;
    step(2);
    in_strobe = '0;
    check("t6_valid", {31'd0, out_valid}, 32'd1);
    check("t6_full", {28'd0, full}, 32'h7);
    check("t6_ovf", {28'd0, overflow}, 32'h6);
    #2;
    rst = 1'b1;
    #1;
    check("t6_rst_valid", {31'd0, out_valid}, 32'd0);
    check("t6_rst_full", {28'd0, full}, 32'd0);
    check("t6_rst_ovf", {28'd0, overflow}, 32'd0);
    rst = 1'b0;
    step(1);

    // clear discards a same-cycle strobe
    clear = 1'b1; in_strobe = 4'b0001; in_data = 32'h0000_0060;
    step(1);
    clear = 1'b0; in_strobe = '0;
    check("t7_full", {28'd0, full}, 32'd0);
    check("t7_valid", {31'd0, out_valid}, 32'd0);
    step(1);
    check("t7_valid2", {31'd0, out_valid}, 32'd0);

    check("sb_leftover", sb_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
